input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Bank of per-channel synchronise-and-debounce filters for the raw push-button and sensor pins (sensor, walk_request, reprogram).
- Sits directly upstream of the traffic-light top level. Its clean levels and edge pulses replace the raw pins, so contact bounce never reaches the walk register or the reprogram path.
- Each channel has a 2-FF synchroniser, a stability counter, a registered clean level and one-cycle rise/fall pulses.

Parameters:
- NUM_CH, 3, number of independent input channels (bit 0 sensor, bit 1 walk_request, bit 2 reprogram). Must be >= 1.
- DEBOUNCE_CYCLES, 16, consecutive synchronised cycles an input must differ from the clean level before the clean level changes. Must be >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each stability counter. Derived; do not override.

Ports:
- clock  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- raw_in  input  NUM_CH  unsynchronised pin levels.
- clean_out  output  NUM_CH  debounced registered level per channel.
- rise_pulse  output  NUM_CH  one-cycle high when clean_out goes 0->1.
- fall_pulse  output  NUM_CH  one-cycle high when clean_out goes 1->0.
- glitch_count  output  8  aborted-transition counter; present only with DEBOUNCE_GLITCH_CNT_EN.

Behaviour:
- Reset (asynchronous, active-high):
  - sync FFs, counters, clean_out, rise_pulse, fall_pulse all 0; glitch_count 0.
  - Effective immediately, independent of clock.
- Synchroniser: sync1 <= raw_in; sync2 <= sync1. All filter logic uses sync2 only.
- Per channel i, per clock edge:
  - sync2[i] == clean_out[i]: cnt[i] <= 0. No change.
  - sync2[i] != clean_out[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync2[i] != clean_out[i] and cnt[i] == DEBOUNCE_CYCLES-1: clean_out[i] <= sync2[i]; cnt[i] <= 0.
  - rise_pulse[i] <= 1 when that update sets clean_out to 1; fall_pulse[i] <= 1 when it sets it to 0. Otherwise the pulses are 0.
- Pulses:
  - Registered, asserted in the same cycle clean_out changes, high exactly one cycle.
  - rise_pulse[i] and fall_pulse[i] are never both high.
- Latency: for a raw change that then stays stable, clean_out updates on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new raw value as edge 1. Default 18 edges.
- Glitch rejection: any mismatch lasting fewer than DEBOUNCE_CYCLES synchronised cycles leaves clean_out and the pulses unchanged, and cnt returns to 0 on the first matching cycle.
- Counter never wraps. Its maximum value is DEBOUNCE_CYCLES-1, and at that value it either transitions or is cleared.
- Channels are fully independent; simultaneous transitions on several channels yield simultaneous pulses.
- Reset mid-count: the count is discarded.
  - After reset release, an input held high needs a full DEBOUNCE_CYCLES+2 edges before rise_pulse.
  - An input held low produces no pulse.
- No combinational path from raw_in to any output.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - 8-bit glitch_count port exists.
  - It increments by 1 on each edge where any channel's cnt is nonzero and sync2 == clean_out (aborted transition).
  - If several channels abort in the same cycle it still increments by 1.
  - Saturates at 255; cleared only by reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: raw_in=000 for 50 cycles -> clean_out=000, no pulses, glitch_count=0.
- Clean press: raw_in[1] 0->1 held 40 cycles -> clean_out[1]=1 and rise_pulse[1] high for exactly one cycle on edge 18 after the change; other channels quiet.
- Bounce: raw_in[0] toggles every 3 cycles for 30 cycles, then holds 1 -> no pulse during toggling; single rise_pulse[0] 18 edges after final stable level; glitch_count >= 1 when the macro is defined.
- Release and simultaneity: raw_in 111->000 on all channels at once after all are clean high -> fall_pulse=111 in the same cycle, clean_out=000.
- Reset mid-count: raw_in[2]=1 for 10 cycles, pulse reset for 1 cycle, keep raw_in[2]=1 -> clean_out[2] rises 18 edges after reset release, not earlier.
- Saturation (macro defined): 300 single-cycle glitches on raw_in[0] -> glitch_count=255, clean_out[0]=0.

Source files
------------

// File: rtl/input_debouncer.sv
// Per-channel 2-FF synchroniser and stability-count debouncer with registered clean level and rise/fall pulses.
// Define DEBOUNCE_GLITCH_CNT_EN to add a saturating 8-bit count of aborted transitions (glitch_count).
module input_debouncer #(
   parameter int NUM_CH          = 3,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_CH-1:0] raw_in,
   output logic [NUM_CH-1:0] clean_out,
   output logic [NUM_CH-1:0] rise_pulse,
   output logic [NUM_CH-1:0] fall_pulse
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [7:0]        glitch_count
`endif
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_CH-1:0] sync1;
   logic [NUM_CH-1:0] sync2;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [NUM_CH-1:0] abort;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw_in;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic             clean_q;
      logic             rise_q;
      logic             fall_q;
      logic             mismatch;

      assign mismatch = sync2[i] ^ clean_q;

      // The counter only advances while the input disagrees; any agreeing cycle discards the run.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            cnt     <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (!mismatch) begin
               cnt <= '0;
            end else if (cnt == CNT_MAX) begin
               cnt     <= '0;
               clean_q <= sync2[i];
               rise_q  <= sync2[i];
               fall_q  <= ~sync2[i];
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end

      assign clean_out[i]  = clean_q;
      assign rise_pulse[i] = rise_q;
      assign fall_pulse[i] = fall_q;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      assign abort[i] = (cnt != '0) && !mismatch;
`endif
   end

`ifdef DEBOUNCE_GLITCH_CNT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         glitch_count <= 8'd0;
      end else if ((|abort) && (glitch_count != 8'hFF)) begin
         glitch_count <= glitch_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Randomized and directed bench for input_debouncer against a history-window reference model.
module tb_input_debouncer;

   localparam int NUM_CH = 3;
   localparam int DB     = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic [NUM_CH-1:0] raw_in;
   logic [NUM_CH-1:0] clean_out;
   logic [NUM_CH-1:0] rise_pulse;
   logic [NUM_CH-1:0] fall_pulse;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0]        glitch_count;
`endif

   always #5 clock = ~clock;

   input_debouncer #(.NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DB)) dut (
      .clock      (clock),
      .reset      (reset),
      .raw_in     (raw_in),
      .clean_out  (clean_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_count (glitch_count)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: raw_hist[k] is the pin value seen at edge k+1 after reset; the filter at
   // edge m acts on the pin value of edge m-2. A level flips at edge n when the last DB filtered
   // values all differ from it and all of them come after the previous flip.
   logic [NUM_CH-1:0] raw_hist[$];
   int                m_n;
   logic [NUM_CH-1:0] m_clean, m_rise, m_fall;
   int                m_last_flip[NUM_CH];
   int                m_glitch;

   function automatic logic used_bit(input int m, input int ch);
      if (m < 3) return 1'b0;
      return raw_hist[m-3][ch];
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         raw_hist.delete();
         m_n      <= 0;
         m_clean  <= '0;
         m_rise   <= '0;
         m_fall   <= '0;
         m_glitch <= 0;
         for (int c = 0; c < NUM_CH; c++) m_last_flip[c] <= 0;
      end else begin : step
         int                n;
         logic [NUM_CH-1:0] nc, nr, nf;
         bit                ab, flip;
         n  = m_n + 1;
         nc = m_clean;
         nr = '0;
         nf = '0;
         ab = 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            flip = (n - m_last_flip[c] >= DB);
            for (int m = n - DB + 1; m <= n && flip; m++)
               if (used_bit(m, c) == m_clean[c]) flip = 1'b0;
            if ((n - 1 > m_last_flip[c]) && (used_bit(n - 1, c) != m_clean[c])
                && (used_bit(n, c) == m_clean[c]))
               ab = 1'b1;
            if (flip) begin
               nc[c] = ~m_clean[c];
               nr[c] = nc[c];
               nf[c] = ~nc[c];
               m_last_flip[c] <= n;
            end
         end
         m_n     <= n;
         m_clean <= nc;
         m_rise  <= nr;
         m_fall  <= nf;
         if (ab && m_glitch < 255) m_glitch <= m_glitch + 1;
         raw_hist.push_back(raw_in);
      end
   end

   bit cmp_en = 1'b0;
   int rise_tally[NUM_CH];
   int fall_tally[NUM_CH];

   always @(negedge clock) begin
      if (cmp_en) begin
         check("clean", clean_out, m_clean);
         check("rise", rise_pulse, m_rise);
         check("fall", fall_pulse, m_fall);
`ifdef DEBOUNCE_GLITCH_CNT_EN
         check("glitch", glitch_count, m_glitch);
`endif
         for (int c = 0; c < NUM_CH; c++) begin
            rise_tally[c] <= rise_tally[c] + int'(rise_pulse[c]);
            fall_tally[c] <= fall_tally[c] + int'(fall_pulse[c]);
         end
      end
   end

   function automatic int total_pulses();
      int s = 0;
      for (int c = 0; c < NUM_CH; c++) s += rise_tally[c] + fall_tally[c];
      return s;
   endfunction

   // Call right after driving at a negedge: the next rising edge is edge 1.
   task automatic wait_pulse(input int ch, input bit rising, output int edges);
      edges = -1;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clock);
         #1;
         if ((rising ? rise_pulse[ch] : fall_pulse[ch]) == 1'b1) begin
            edges = e;
            break;
         end
      end
   endtask

   int lat;
   int r0;
   int hold[NUM_CH];

   initial begin
      for (int c = 0; c < NUM_CH; c++) begin
         rise_tally[c] = 0;
         fall_tally[c] = 0;
      end
      reset  = 1'b1;
      raw_in = '0;
      repeat (2) @(negedge clock);
      check("rst_clean", clean_out, 0);
      check("rst_rise", rise_pulse, 0);
      check("rst_fall", fall_pulse, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("rst_glitch", glitch_count, 0);
`endif
      reset  = 1'b0;
      cmp_en = 1'b1;

      repeat (50) @(negedge clock);
      check("idle_clean", clean_out, 0);
      check("idle_pulses", total_pulses(), 0);

      raw_in[1] = 1'b1;
      wait_pulse(1, 1'b1, lat);
      check("press_lat", lat, DB + 2);
      check("press_clean", clean_out, 3'b010);
      check("press_rise", rise_pulse, 3'b010);
      @(posedge clock);
      #1;
      check("press_1cyc", rise_pulse, 0);
      repeat (20) @(negedge clock);
      check("press_quiet", rise_tally[0] + rise_tally[2], 0);

      r0 = rise_tally[0];
      for (int k = 0; k < 30; k++) begin
         raw_in[0] = (((k / 3) % 2) == 0);
         @(negedge clock);
      end
      raw_in[0] = 1'b1;
      check("bounce_nopulse", rise_tally[0] - r0, 0);
      wait_pulse(0, 1'b1, lat);
      check("bounce_lat", lat, DB + 2);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("bounce_glitch", glitch_count >= 8'd1, 1);
`endif

      @(negedge clock);
      raw_in = 3'b111;
      repeat (25) @(negedge clock);
      check("all_high", clean_out, 3'b111);
      raw_in = 3'b000;
      wait_pulse(0, 1'b0, lat);
      check("release_lat", lat, DB + 2);
      check("release_fall", fall_pulse, 3'b111);
      check("release_clean", clean_out, 3'b000);

      @(negedge clock);
      raw_in[2] = 1'b1;
      repeat (10) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("midrst_clean", clean_out, 0);
      reset = 1'b0;
      wait_pulse(2, 1'b1, lat);
      check("midrst_lat", lat, DB + 2);
      check("midrst_rise", rise_pulse, 3'b100);

      @(negedge clock);
      for (int c = 0; c < NUM_CH; c++) hold[c] = 0;
      for (int k = 0; k < 2000; k++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (hold[c] == 0) begin
               raw_in[c] = $urandom_range(1, 0) == 1;
               hold[c]   = $urandom_range(40, 1);
            end
            hold[c]--;
         end
         @(negedge clock);
      end
      raw_in = '0;
      repeat (30) @(negedge clock);
      check("rand_settle", clean_out, 0);

`ifdef DEBOUNCE_GLITCH_CNT_EN
      for (int k = 0; k < 300; k++) begin
         raw_in[0] = 1'b1;
         @(negedge clock);
         raw_in[0] = 1'b0;
         @(negedge clock);
      end
      repeat (5) @(negedge clock);
      check("sat_glitch", glitch_count, 255);
      check("sat_clean0", clean_out[0], 0);
`endif

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
